// File: rtl/muldiv_seq_if.sv
// Request/result bundle of the sequential multiply/divide unit.
// Optional MULDIV_DIV0_FLAG_EN adds the div_by_zero status line.
interface muldiv_seq_if #(
   parameter int XLEN = 32
);
   logic            start;
   logic            md_is_mult;
   logic            md_is_unsigned;
   logic [XLEN-1:0] op_a;
   logic [XLEN-1:0] op_b;
   logic            busy;
   logic            done;
   logic [XLEN-1:0] hi;
   logic [XLEN-1:0] lo;
`ifdef MULDIV_DIV0_FLAG_EN
   logic            div_by_zero;

   modport master (
      output start, md_is_mult, md_is_unsigned, op_a, op_b,
      input  busy, done, hi, lo, div_by_zero
   );
   modport slave (
      input  start, md_is_mult, md_is_unsigned, op_a, op_b,
      output busy, done, hi, lo, div_by_zero
   );
`else
   modport master (
      output start, md_is_mult, md_is_unsigned, op_a, op_b,
      input  busy, done, hi, lo
   );
   modport slave (
      input  start, md_is_mult, md_is_unsigned, op_a, op_b,
      output busy, done, hi, lo
   );
`endif
endinterface

// File: rtl/muldiv_seq.sv
// Radix-2 sequential MULT/MULTU/DIV/DIVU with HI/LO registers (XLEN+1 cycle latency).
// Optional MULDIV_DIV0_FLAG_EN adds a sticky-until-next-commit div_by_zero output.
module muldiv_seq #(
   parameter int XLEN = 32
) (
   input  logic        clk,
   input  logic        rst,
   muldiv_seq_if.slave bus
);
   localparam int CW = $clog2(XLEN);
   localparam logic [CW-1:0] LAST = CW'(XLEN - 1);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} state_t;

   state_t            r_state;
   state_t            w_state_next;
   logic [CW-1:0]     r_cnt;
   logic              r_is_mult;
   logic              r_div0;
   logic              r_neg_q;
   logic              r_neg_r;
   logic [XLEN-1:0]   r_m;
   logic [XLEN-1:0]   r_raw_a;
   logic [2*XLEN-1:0] r_acc;
   logic [XLEN-1:0]   r_hi;
   logic [XLEN-1:0]   r_lo;
   logic              r_done;
   logic              w_busy;

   logic [XLEN-1:0]   w_abs_a;
   logic [XLEN-1:0]   w_abs_b;
   logic [XLEN:0]     w_sum;
   logic [XLEN:0]     w_rem_sh;
   logic [XLEN:0]     w_diff;
   logic [2*XLEN-1:0] w_acc_step;
   logic [2*XLEN-1:0] w_prod;
   logic [XLEN-1:0]   w_quot;
   logic [XLEN-1:0]   w_rem;

   assign w_abs_a = (!bus.md_is_unsigned && bus.op_a[XLEN-1]) ? -bus.op_a : bus.op_a;
   assign w_abs_b = (!bus.md_is_unsigned && bus.op_b[XLEN-1]) ? -bus.op_b : bus.op_b;

   // Multiply: accumulator is {partial product, remaining multiplier bits}, shifted right.
   assign w_sum = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_acc[0] ? {1'b0, r_m} : '0);

   // Divide: accumulator is {partial remainder, remaining dividend/quotient bits}, shifted left.
   assign w_rem_sh = {r_acc[2*XLEN-1:XLEN], r_acc[XLEN-1]};
   assign w_diff   = w_rem_sh - {1'b0, r_m};

   always_comb begin
      w_acc_step = r_acc;
      if (r_is_mult) begin
         w_acc_step = {w_sum, r_acc[XLEN-1:1]};
      end else if (!w_diff[XLEN]) begin
         w_acc_step = {w_diff[XLEN-1:0], r_acc[XLEN-2:0], 1'b1};
      end else begin
         w_acc_step = {w_rem_sh[XLEN-1:0], r_acc[XLEN-2:0], 1'b0};
      end
   end

   assign w_prod = r_neg_q ? -r_acc : r_acc;
   assign w_quot = r_neg_q ? -r_acc[XLEN-1:0] : r_acc[XLEN-1:0];
   assign w_rem  = r_neg_r ? -r_acc[2*XLEN-1:XLEN] : r_acc[2*XLEN-1:XLEN];

   always_ff @(posedge clk) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_state_next;
   end

   always_comb begin
      w_state_next = r_state;
      w_busy       = 1'b0;
      case (r_state)
         S_IDLE: if (bus.start) w_state_next = S_RUN;
         S_RUN: begin
            w_busy = 1'b1;
            if (r_cnt == LAST) w_state_next = S_FIX;
         end
         S_FIX: begin
            w_busy       = 1'b1;
            w_state_next = S_IDLE;
         end
         default: w_state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt     <= '0;
         r_is_mult <= 1'b0;
         r_div0    <= 1'b0;
         r_neg_q   <= 1'b0;
         r_neg_r   <= 1'b0;
         r_m       <= '0;
         r_raw_a   <= '0;
         r_acc     <= '0;
         r_hi      <= '0;
         r_lo      <= '0;
         r_done    <= 1'b0;
      end else begin
         r_done <= (r_state == S_FIX);
         case (r_state)
            S_IDLE: if (bus.start) begin
               r_cnt     <= '0;
               r_is_mult <= bus.md_is_mult;
               r_div0    <= !bus.md_is_mult && (bus.op_b == '0);
               r_neg_q   <= !bus.md_is_unsigned && (bus.op_a[XLEN-1] ^ bus.op_b[XLEN-1]);
               r_neg_r   <= !bus.md_is_unsigned && bus.op_a[XLEN-1];
               r_m       <= bus.md_is_mult ? w_abs_a : w_abs_b;
               r_acc     <= {{XLEN{1'b0}}, bus.md_is_mult ? w_abs_b : w_abs_a};
               r_raw_a   <= bus.op_a;
            end
            S_RUN: begin
               r_acc <= w_acc_step;
               r_cnt <= r_cnt + 1'b1;
            end
            S_FIX: begin
               if (r_is_mult) begin
                  r_hi <= w_prod[2*XLEN-1:XLEN];
                  r_lo <= w_prod[XLEN-1:0];
               end else if (r_div0) begin
                  r_hi <= r_raw_a;
                  r_lo <= '1;
               end else begin
                  r_hi <= w_rem;
                  r_lo <= w_quot;
               end
            end
            default: ;
         endcase
      end
   end

`ifdef MULDIV_DIV0_FLAG_EN
   logic r_dz;
   always_ff @(posedge clk) begin
      if (rst)                   r_dz <= 1'b0;
      else if (r_state == S_FIX) r_dz <= r_div0;
   end
   assign bus.div_by_zero = r_dz;
`endif

   assign bus.busy = w_busy;
   assign bus.done = r_done;
   assign bus.hi   = r_hi;
   assign bus.lo   = r_lo;
endmodule
